// File: rtl/cim_shift_accumulator_if.sv
// cim_shift_accumulator_if: plane-issue, tree-sum and result handshake bundle
interface cim_shift_accumulator_if #(
  parameter int PSUM_W = 10,
  parameter int ACC_W  = 16
);
  logic              plane_issue;
  logic              plane_first;
  logic              flush;
  logic [PSUM_W-1:0] psum_in;
  logic [ACC_W-1:0]  result;
  logic              result_valid;
  logic              result_ready;
  logic              busy;
  logic              overrun;
  logic              seq_err;
  modport master (
    output plane_issue, plane_first, flush, psum_in, result_ready,
    input  result, result_valid, busy, overrun, seq_err
  );
  modport slave (
    input  plane_issue, plane_first, flush, psum_in, result_ready,
    output result, result_valid, busy, overrun, seq_err
  );
endinterface

// File: rtl/cim_shift_accumulator.sv
// cim_shift_accumulator: aligns adder-tree psums to plane issues and shift-accumulates MSB-first
module cim_shift_accumulator #(
  parameter int PSUM_W     = 10,
  parameter int NUM_BITS   = 4,
  parameter int ACC_W      = 16,
  parameter int TREE_LAT   = 4,
  parameter int SIGNED_ACT = 1
) (
  input logic                    clk,
  input logic                    RSTN,
  cim_shift_accumulator_if.slave bus
);
  localparam int CW = $clog2(NUM_BITS + 1);
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t              state_q, state_d;
  logic [TREE_LAT-1:0] iss_q, iss_d, fst_q, fst_d;
  logic [ACC_W-1:0]    acc_q, acc_d, res_q, res_d, sx;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                rv_q, rv_d, ovr_q, ovr_d, err_q, err_d;
  logic                arr, arr_first, done, bad, load;
  assign arr       = iss_q[TREE_LAT-1];
  assign arr_first = fst_q[TREE_LAT-1];
  assign sx        = ACC_W'(signed'(bus.psum_in));
  assign iss_d     = bus.flush ? '0 : TREE_LAT'({iss_q, bus.plane_issue});
  assign fst_d     = bus.flush ? '0 : TREE_LAT'({fst_q, bus.plane_issue & bus.plane_first});
  // Plane arrival FSM and result/flag next-state
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    bad     = 1'b0;
    if (bus.flush) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (arr && arr_first) begin
      acc_d   = (SIGNED_ACT != 0) ? -sx : sx;
      cnt_d   = CW'(1);
      state_d = ACCUM;
      bad     = (state_q == ACCUM);
    end else if (arr && state_q == IDLE) begin
      bad = 1'b1;
    end else if (arr) begin
      acc_d = (acc_q << 1) + sx;
      cnt_d = cnt_q + CW'(1);
      if (cnt_d == CW'(NUM_BITS)) begin
        done    = 1'b1;
        state_d = IDLE;
      end
    end
    load  = done && (!rv_q || bus.result_ready);
    res_d = load ? acc_d : res_q;
    rv_d  = load | (rv_q & ~bus.result_ready);
    ovr_d = ovr_q | (done & ~load);
    err_d = err_q | bad;
  end
  // State, delay lines and output registers
  always_ff @(posedge clk) begin
    if (!RSTN) begin
      state_q <= IDLE;
      iss_q   <= '0;
      fst_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      rv_q    <= 1'b0;
      ovr_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      iss_q   <= iss_d;
      fst_q   <= fst_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      rv_q    <= rv_d;
      ovr_q   <= ovr_d;
      err_q   <= err_d;
    end
  end
  assign bus.result       = res_q;
  assign bus.result_valid = rv_q;
  assign bus.overrun      = ovr_q;
  assign bus.seq_err      = err_q;
  assign bus.busy         = (state_q == ACCUM) | (|iss_q);
endmodule

// File: tb/tb_cim_shift_accumulator.sv
// tb_cim_shift_accumulator: signed and unsigned instances against an operation-level model
module tb_cim_shift_accumulator;
  localparam int L  = 4;
  localparam int NB = 4;
  logic clk = 1'b0, rstn = 1'b0;
  logic issue = 1'b0, first = 1'b0, flush = 1'b0, ready = 1'b0;
  logic [9:0] psum = '0;
  int n_assert = 0, n_fail = 0, cyc = 0;
  always #5 clk = ~clk;

  cim_shift_accumulator_if #(.PSUM_W(10), .ACC_W(16)) ia ();
  cim_shift_accumulator_if #(.PSUM_W(10), .ACC_W(16)) ib ();
  assign ia.plane_issue = issue;  assign ib.plane_issue = issue;
  assign ia.plane_first = first;  assign ib.plane_first = first;
  assign ia.flush = flush;        assign ib.flush = flush;
  assign ia.psum_in = psum;       assign ib.psum_in = psum;
  assign ia.result_ready = ready; assign ib.result_ready = ready;
  cim_shift_accumulator #(.PSUM_W(10), .NUM_BITS(NB), .ACC_W(16), .TREE_LAT(L), .SIGNED_ACT(1))
    dut_s (.clk(clk), .RSTN(rstn), .bus(ia));
  cim_shift_accumulator #(.PSUM_W(10), .NUM_BITS(NB), .ACC_W(16), .TREE_LAT(L), .SIGNED_ACT(0))
    dut_u (.clk(clk), .RSTN(rstn), .bus(ib));

  typedef struct {int t; bit f;} fl_t;
  fl_t inflight[$];
  int plist[$];
  int psched[int];
  bit active = 0, mrv = 0, movr = 0, merr = 0;
  logic [15:0] mres[2] = '{16'h0, 16'h0};

  function automatic logic [15:0] opval(bit s);
    longint v = 0;
    for (int k = 0; k < NB; k++) begin
      longint w = longint'(1) << (NB - 1 - k);
      if (s && k == 0) w = -w;
      v += longint'(plist[k]) * w;
    end
    return 16'(v);
  endfunction

  task automatic model_update();
    bit arr = 0, af = 0, done = 0;
    int p = int'($signed(psum));
    if (!rstn) begin
      inflight.delete(); plist.delete();
      active = 0; mrv = 0; movr = 0; merr = 0; mres = '{16'h0, 16'h0};
      return;
    end
    if (inflight.size() > 0 && inflight[0].t == cyc) begin
      arr = 1; af = inflight[0].f; void'(inflight.pop_front());
    end
    if (flush) begin
      inflight.delete(); plist.delete(); active = 0;
    end else begin
      if (arr) begin
        if (af) begin
          if (active) merr = 1;
          plist.delete(); plist.push_back(p); active = 1;
        end else if (!active) merr = 1;
        else begin
          plist.push_back(p);
          if (plist.size() == NB) begin done = 1; active = 0; end
        end
      end
      if (issue) inflight.push_back('{cyc + L, first});
    end
    if (done && (!mrv || ready)) begin
      mres[0] = opval(1); mres[1] = opval(0); mrv = 1;
    end else begin
      if (done) movr = 1;
      if (ready) mrv = 0;
    end
  endtask

  task automatic chk(string n, int a, int e);
    n_assert++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic check_all();
    int mb = int'(active || inflight.size() > 0);
    chk("s.result", int'(ia.result), int'(mres[0]));
    chk("u.result", int'(ib.result), int'(mres[1]));
    chk("s.valid", int'(ia.result_valid), int'(mrv));
    chk("u.valid", int'(ib.result_valid), int'(mrv));
    chk("s.busy", int'(ia.busy), mb);
    chk("u.busy", int'(ib.busy), mb);
    chk("s.overrun", int'(ia.overrun), int'(movr));
    chk("u.overrun", int'(ib.overrun), int'(movr));
    chk("s.seq_err", int'(ia.seq_err), int'(merr));
    chk("u.seq_err", int'(ib.seq_err), int'(merr));
  endtask

  task automatic step();
    if (psched.exists(cyc)) begin psum = 10'(psched[cyc]); psched.delete(cyc); end
    else psum = 10'($urandom);
    model_update();
    @(posedge clk); #1;
    cyc++;
    check_all();
    issue = 0; first = 0; flush = 0;
  endtask

  task automatic issue_plane(bit f, int v);
    issue = 1; first = f; psched[cyc + L] = v;
    step();
  endtask

  task automatic run_op(int a, int b, int c, int d);
    issue_plane(1, a); issue_plane(0, b); issue_plane(0, c); issue_plane(0, d);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {int ps[4]; int es; int eu;} vec_t;
  vec_t tv[6];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, seqpos;
    tv[0] = '{'{3, -2, 5, 1}, -21, 27};
    tv[1] = '{'{15, 15, 15, 15}, -15, 225};
    tv[2] = '{'{0, 0, 0, 1}, 1, 1};
    tv[3] = '{'{-512, -512, -512, -512}, 512, -7680};
    tv[4] = '{'{511, 0, 0, 0}, -4088, 4088};
    tv[5] = '{'{-1, 3, -7, 2}, 8, -8};

    @(negedge clk);
    rstn = 0; idle(2);
    chk("rst.result", int'(ia.result), 0);
    chk("rst.valid", int'(ia.result_valid), 0);
    chk("rst.busy", int'(ia.busy), 0);
    rstn = 1; idle(6);
    chk("nois.valid", int'(ia.result_valid), 0);
    chk("nois.busy", int'(ib.busy), 0);

    for (int i = 0; i < 6; i++) begin
      run_op(tv[i].ps[0], tv[i].ps[1], tv[i].ps[2], tv[i].ps[3]);
      n = 0;
      while (!ia.result_valid && n < 20) begin step(); n++; end
      chk("tbl.latency", n, L);
      chk("tbl.s", int'($signed(ia.result)), tv[i].es);
      chk("tbl.u", int'($signed(ib.result)), tv[i].eu);
      idle(2);
      chk("tbl.hold", int'(ia.result_valid), 1);
      ready = 1; step(); ready = 0;
      chk("tbl.drop", int'(ia.result_valid), 0);
    end
    chk("tbl.seq_err", int'(ia.seq_err), 0);

    run_op(0, 0, 3, 1); run_op(0, 0, 4, 1); idle(L + 2);
    chk("ovr.result", int'($signed(ia.result)), 7);
    chk("ovr.flag", int'(ia.overrun), 1);
    chk("ovr.valid", int'(ib.result_valid), 1);
    ready = 1; step(); ready = 0;
    chk("ovr.drop", int'(ia.result_valid), 0);

    issue_plane(1, 5); issue_plane(0, 5);
    run_op(1, 1, 1, 1); idle(L + 2);
    chk("seq.s", int'($signed(ia.result)), -1);
    chk("seq.u", int'($signed(ib.result)), 15);
    chk("seq.err", int'(ia.seq_err), 1);
    ready = 1; step(); ready = 0;
    issue_plane(0, 3); idle(L + 2);
    chk("seq.idle_valid", int'(ia.result_valid), 0);
    chk("seq.idle_err", int'(ib.seq_err), 1);
    chk("seq.idle_res", int'($signed(ia.result)), -1);

    issue_plane(1, 2); issue_plane(0, 2); issue_plane(0, 2);
    rstn = 0; step(); rstn = 1;
    chk("mrst.busy", int'(ia.busy), 0);
    chk("mrst.err", int'(ia.seq_err), 0);
    idle(L + 3);
    chk("mrst.valid", int'(ia.result_valid), 0);
    run_op(0, 0, 4, 1); idle(L + 2);
    chk("mrst.res", int'($signed(ia.result)), 9);
    ready = 1; step(); ready = 0;
    issue_plane(1, 7); issue_plane(0, 7);
    flush = 1; step();
    idle(L + 2);
    chk("flush.busy", int'(ia.busy), 0);
    run_op(-1, 3, -7, 2); idle(L + 2);
    chk("flush.res", int'($signed(ia.result)), 8);
    chk("flush.err", int'(ia.seq_err), 0);
    ready = 1; step();

    seqpos = 0;
    for (int i = 0; i < 3000; i++) begin
      rstn  = ($urandom % 400) != 0;
      flush = ($urandom % 40) == 0;
      issue = ($urandom % 3) != 0;
      ready = ($urandom % 2) != 0;
      if (issue) begin
        first = (seqpos == 0);
        if ($urandom % 12 == 0) first = ~first;
        seqpos = (seqpos + 1) % NB;
      end
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
